fir_27tap: RTL and testbench
============================

// Module: fir_27tap
// PURPOSE
//   27-tap direct-form FIR filter: a 4-bit signed sample shift register (taps exported)
//   multiplied by 27 externally supplied 9-bit signed coefficients, summed and registered.
//   Datapath block; coefficients come from a higher-level coefficient store.
// PARAMETERS
//   None overridable. Fixed sizing (localparams):
//   NTAPS  27  number of taps / coefficients
//   DW     4   sample width, signed two's complement
//   CW     9   coefficient width, signed two's complement
//   OW     16  output width, signed two's complement
// PORTS
//   clk                  in   1   rising-edge clock
//   rst_n                in   1   reset, synchronous, active-low
//   en_n                 in   1   active-low enable; 1 = hold all state
//   clr                  in   1   synchronous clear of taps and output, active-high
//   i_mag                in   4   input sample, signed (4'b1001 = -7)
//   h_buf_0..h_buf_26    in   9   coefficient k (signed), applied to tap k
//   i_mul_0..i_mul_26    out  4   tap registers, signed; i_mul_0 = newest sample
//   out                  out  16  registered filter output, signed
// BEHAVIOUR
//   - All state updates on posedge clk. Priority: rst_n=0 > clr=1 > en_n=0 > hold.
//   - Reset (rst_n=0): all i_mul_k = 0, out = 0. clr=1 (rst_n=1): same, regardless of en_n.
//   - en_n=0, clr=0: i_mul_0 <= i_mag; i_mul_k <= i_mul_(k-1), k=1..26;
//     out <= SUM_k (i_mul_k * h_buf_k) using tap values BEFORE this edge's shift.
//   - en_n=1: taps and out hold; coefficient changes have no effect until next enabled edge.
//   - Latency: sample presented before edge E enters i_mul_0 at E; first contributes
//     h_buf_0*sample to out at E+1; last contributes at E+27.
//   - Arithmetic: each product signed 4x9 -> 13 bits; accumulate signed in >=18 bits
//     (no internal overflow); result reduced to 16 bits by two's-complement wrap
//     (keep low 16 bits) unless FIR_SAT_EN is defined.
//   - Coefficients are used as given; no symmetry is assumed or exploited.
//   - out is a pure register: no combinational path from i_mag/h_buf_* to out.
//   - Reset or clr asserted mid-stream discards all history; refill takes 27 enabled edges.
// CONFIGURATION
//   FIR_SAT_EN defined: 16-bit output saturates: sum > 32767 -> 32767,
//     sum < -32768 -> -32768. Not defined: wrap to low 16 bits (default build).
// TESTING
//   Nominal coefficient set (h0..h13 = 1,4,0,6,1,8,4,9,10,11,23,12,79,140;
//   h14..h26 = 79,12,23,11,10,9,4,8,1,6,0,4,1; sum = 476) unless stated.
//   1 Hold rst_n=0 several edges, i_mag=9, en_n=1 -> out=0, all i_mul_k=0.
//   2 After clr, en_n=0: i_mag=1 one cycle then 0 -> out sequence 1,4,0,6,1,8,...,4,1
//     (coefficients in order) starting one edge after capture, then 0.
//   3 i_mag=1 held >=28 enabled edges -> out settles to 476; i_mag=4'b1001 held -> -3332.
//   4 Ramp i_mag 0..15 one per edge -> out matches per-edge reference model
//     SUM(i_mul_k*h_buf_k) registered; i_mul_k shifts by one tap per edge.
//   5 Mid-stream en_n=1 for 5 edges -> taps and out frozen; clr=1 one edge -> all 0;
//     rst_n=0 with clr=1 and en_n=0 -> all 0.
//   6 All h_buf=9'h0FF, i_mag=7 steady -> sum 48195: out=-17341 (wrap) / 32767 (FIR_SAT_EN);
//     i_mag=4'b1000 -> -55080: out=10456 (wrap) / -32768 (FIR_SAT_EN).

Source files
------------

// File: rtl/fir_27tap.sv
// ---------------------------------------------------------------------------
// fir_27tap
//   27-tap direct-form FIR filter. A 4-bit signed sample shift register
//   (every tap exported) is multiplied tap-by-tap with 27 externally
//   supplied 9-bit signed coefficients; the products are summed and the
//   sum is registered into a 16-bit signed output.
//
//   No valid/ready handshake: the block advances one sample on every
//   rising edge where en_n=0, and holds all state otherwise.
//
// Ports
//   clk                 in   1   rising-edge clock
//   rst_n               in   1   synchronous reset, active-low
//   en_n                in   1   active-low enable (1 = hold all state)
//   clr                 in   1   synchronous clear of taps and output
//   i_mag               in   4   input sample, signed
//   h_buf_0..h_buf_26   in   9   coefficient k (signed), applied to tap k
//   i_mul_0..i_mul_26   out  4   tap registers (signed), i_mul_0 = newest
//   out                 out  16  registered filter output, signed
//
// Configuration
//   FIR_SAT_EN  defined   : 16-bit output saturates at 32767 / -32768.
//               undefined : output is the low 16 bits of the sum (wrap).
//
// Priority on each edge: rst_n=0 > clr=1 > en_n=0 > hold.
// out is computed from the taps as they were BEFORE the same edge's shift,
// so a sample captured at edge E first shows up in out at E+1.
// ---------------------------------------------------------------------------
module fir_27tap (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en_n,
   input  logic        clr,
   input  logic [3:0]  i_mag,
   input  logic [8:0]  h_buf_0,
   input  logic [8:0]  h_buf_1,
   input  logic [8:0]  h_buf_2,
   input  logic [8:0]  h_buf_3,
   input  logic [8:0]  h_buf_4,
   input  logic [8:0]  h_buf_5,
   input  logic [8:0]  h_buf_6,
   input  logic [8:0]  h_buf_7,
   input  logic [8:0]  h_buf_8,
   input  logic [8:0]  h_buf_9,
   input  logic [8:0]  h_buf_10,
   input  logic [8:0]  h_buf_11,
   input  logic [8:0]  h_buf_12,
   input  logic [8:0]  h_buf_13,
   input  logic [8:0]  h_buf_14,
   input  logic [8:0]  h_buf_15,
   input  logic [8:0]  h_buf_16,
   input  logic [8:0]  h_buf_17,
   input  logic [8:0]  h_buf_18,
   input  logic [8:0]  h_buf_19,
   input  logic [8:0]  h_buf_20,
   input  logic [8:0]  h_buf_21,
   input  logic [8:0]  h_buf_22,
   input  logic [8:0]  h_buf_23,
   input  logic [8:0]  h_buf_24,
   input  logic [8:0]  h_buf_25,
   input  logic [8:0]  h_buf_26,
   output logic [3:0]  i_mul_0,
   output logic [3:0]  i_mul_1,
   output logic [3:0]  i_mul_2,
   output logic [3:0]  i_mul_3,
   output logic [3:0]  i_mul_4,
   output logic [3:0]  i_mul_5,
   output logic [3:0]  i_mul_6,
   output logic [3:0]  i_mul_7,
   output logic [3:0]  i_mul_8,
   output logic [3:0]  i_mul_9,
   output logic [3:0]  i_mul_10,
   output logic [3:0]  i_mul_11,
   output logic [3:0]  i_mul_12,
   output logic [3:0]  i_mul_13,
   output logic [3:0]  i_mul_14,
   output logic [3:0]  i_mul_15,
   output logic [3:0]  i_mul_16,
   output logic [3:0]  i_mul_17,
   output logic [3:0]  i_mul_18,
   output logic [3:0]  i_mul_19,
   output logic [3:0]  i_mul_20,
   output logic [3:0]  i_mul_21,
   output logic [3:0]  i_mul_22,
   output logic [3:0]  i_mul_23,
   output logic [3:0]  i_mul_24,
   output logic [3:0]  i_mul_25,
   output logic [3:0]  i_mul_26,
   output logic [15:0] out
);

   localparam int NTAPS = 27;
   localparam int DW    = 4;
   localparam int CW    = 9;
   localparam int OW    = 16;
   localparam int PW    = DW + CW;   // full-precision 4x9 signed product

`ifdef FIR_SAT_EN
   // Worst case |sum| = 27 * 8 * 256 = 55296, so 20 bits never overflow and
   // the saturation compare sees the true sum.
   localparam int AW = 20;
`else
   // Wrapped output only needs the sum modulo 2^16, and two's-complement
   // addition modulo 2^16 gives the same low 16 bits as a wide accumulator.
   localparam int AW = OW;
`endif

   logic signed [DW-1:0] taps [NTAPS];
   logic signed [CW-1:0] coef [NTAPS];
   logic signed [PW-1:0] prod [NTAPS];
   logic signed [AW-1:0] acc;
   logic        [OW-1:0] out_next;

   assign coef[0]  = h_buf_0;
   assign coef[1]  = h_buf_1;
   assign coef[2]  = h_buf_2;
   assign coef[3]  = h_buf_3;
   assign coef[4]  = h_buf_4;
   assign coef[5]  = h_buf_5;
   assign coef[6]  = h_buf_6;
   assign coef[7]  = h_buf_7;
   assign coef[8]  = h_buf_8;
   assign coef[9]  = h_buf_9;
   assign coef[10] = h_buf_10;
   assign coef[11] = h_buf_11;
   assign coef[12] = h_buf_12;
   assign coef[13] = h_buf_13;
   assign coef[14] = h_buf_14;
   assign coef[15] = h_buf_15;
   assign coef[16] = h_buf_16;
   assign coef[17] = h_buf_17;
   assign coef[18] = h_buf_18;
   assign coef[19] = h_buf_19;
   assign coef[20] = h_buf_20;
   assign coef[21] = h_buf_21;
   assign coef[22] = h_buf_22;
   assign coef[23] = h_buf_23;
   assign coef[24] = h_buf_24;
   assign coef[25] = h_buf_25;
   assign coef[26] = h_buf_26;

   assign i_mul_0  = taps[0];
   assign i_mul_1  = taps[1];
   assign i_mul_2  = taps[2];
   assign i_mul_3  = taps[3];
   assign i_mul_4  = taps[4];
   assign i_mul_5  = taps[5];
   assign i_mul_6  = taps[6];
   assign i_mul_7  = taps[7];
   assign i_mul_8  = taps[8];
   assign i_mul_9  = taps[9];
   assign i_mul_10 = taps[10];
   assign i_mul_11 = taps[11];
   assign i_mul_12 = taps[12];
   assign i_mul_13 = taps[13];
   assign i_mul_14 = taps[14];
   assign i_mul_15 = taps[15];
   assign i_mul_16 = taps[16];
   assign i_mul_17 = taps[17];
   assign i_mul_18 = taps[18];
   assign i_mul_19 = taps[19];
   assign i_mul_20 = taps[20];
   assign i_mul_21 = taps[21];
   assign i_mul_22 = taps[22];
   assign i_mul_23 = taps[23];
   assign i_mul_24 = taps[24];
   assign i_mul_25 = taps[25];
   assign i_mul_26 = taps[26];

   // Multiply-accumulate over the current (pre-shift) taps. Operands are
   // sign-extended to the product width before multiplying so the product
   // keeps full signed precision.
   always_comb begin
      acc = '0;
      for (int k = 0; k < NTAPS; k++) begin
         prod[k] = PW'(taps[k]) * PW'(coef[k]);
         acc     = acc + AW'(prod[k]);
      end
   end

`ifdef FIR_SAT_EN
   localparam logic signed [AW-1:0] SAT_MAX = AW'(32767);
   localparam logic signed [AW-1:0] SAT_MIN = AW'(-32768);

   always_comb begin
      out_next = acc[OW-1:0];
      if (acc > SAT_MAX) begin
         out_next = 16'h7FFF;
      end else if (acc < SAT_MIN) begin
         out_next = 16'h8000;
      end
   end
`else
   assign out_next = acc;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         for (int k = 0; k < NTAPS; k++) begin
            taps[k] <= '0;
         end
         out <= '0;
      end else if (!en_n) begin
         taps[0] <= i_mag;
         for (int k = 1; k < NTAPS; k++) begin
            taps[k] <= taps[k-1];
         end
         out <= out_next;
      end
   end

endmodule

// File: tb/tb_fir_27tap.sv
module tb_fir_27tap;

   logic        clk;
   logic        rst_n;
   logic        en_n;
   logic        clr;
   logic [3:0]  i_mag;
   logic [8:0]  h [27];
   logic [3:0]  tap_o [27];
   logic [15:0] out;

   // bench-side model state
   logic [3:0]  mt [27];
   logic [15:0] last_exp;
   logic [15:0] exp_q [$];
   int          n_checks;
   int          n_fail;

   localparam logic [8:0] NOM [27] = '{9'd1, 9'd4, 9'd0, 9'd6, 9'd1, 9'd8, 9'd4, 9'd9, 9'd10,
                                       9'd11, 9'd23, 9'd12, 9'd79, 9'd140, 9'd79, 9'd12, 9'd23,
                                       9'd11, 9'd10, 9'd9, 9'd4, 9'd8, 9'd1, 9'd6, 9'd0, 9'd4, 9'd1};

   fir_27tap dut (
      .clk(clk), .rst_n(rst_n), .en_n(en_n), .clr(clr), .i_mag(i_mag),
      .h_buf_0(h[0]),   .h_buf_1(h[1]),   .h_buf_2(h[2]),   .h_buf_3(h[3]),
      .h_buf_4(h[4]),   .h_buf_5(h[5]),   .h_buf_6(h[6]),   .h_buf_7(h[7]),
      .h_buf_8(h[8]),   .h_buf_9(h[9]),   .h_buf_10(h[10]), .h_buf_11(h[11]),
      .h_buf_12(h[12]), .h_buf_13(h[13]), .h_buf_14(h[14]), .h_buf_15(h[15]),
      .h_buf_16(h[16]), .h_buf_17(h[17]), .h_buf_18(h[18]), .h_buf_19(h[19]),
      .h_buf_20(h[20]), .h_buf_21(h[21]), .h_buf_22(h[22]), .h_buf_23(h[23]),
      .h_buf_24(h[24]), .h_buf_25(h[25]), .h_buf_26(h[26]),
      .i_mul_0(tap_o[0]),   .i_mul_1(tap_o[1]),   .i_mul_2(tap_o[2]),   .i_mul_3(tap_o[3]),
      .i_mul_4(tap_o[4]),   .i_mul_5(tap_o[5]),   .i_mul_6(tap_o[6]),   .i_mul_7(tap_o[7]),
      .i_mul_8(tap_o[8]),   .i_mul_9(tap_o[9]),   .i_mul_10(tap_o[10]), .i_mul_11(tap_o[11]),
      .i_mul_12(tap_o[12]), .i_mul_13(tap_o[13]), .i_mul_14(tap_o[14]), .i_mul_15(tap_o[15]),
      .i_mul_16(tap_o[16]), .i_mul_17(tap_o[17]), .i_mul_18(tap_o[18]), .i_mul_19(tap_o[19]),
      .i_mul_20(tap_o[20]), .i_mul_21(tap_o[21]), .i_mul_22(tap_o[22]), .i_mul_23(tap_o[23]),
      .i_mul_24(tap_o[24]), .i_mul_25(tap_o[25]), .i_mul_26(tap_o[26]),
      .out(out)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, expv);
      end
   endtask

   // Filter reference: signed sum of current model taps times coefficients.
   function automatic logic [15:0] model_out();
      int acc;
      acc = 0;
      for (int k = 0; k < 27; k++) begin
         acc += int'($signed(mt[k])) * int'($signed(h[k]));
      end
`ifdef FIR_SAT_EN
      if (acc > 32767) return 16'h7FFF;
      if (acc < -32768) return 16'h8000;
`endif
      return 16'(acc);
   endfunction

   // ---------------- driver ----------------
   // Drives one edge worth of inputs, predicts the result into the
   // scoreboard queue, then compares out and all taps after the edge.
   task automatic step(input logic r, input logic c, input logic e, input logic [3:0] m);
      logic [15:0] expv;
      rst_n = r;
      clr   = c;
      en_n  = e;
      i_mag = m;
      if (!r || c) begin
         expv = 16'h0;
         for (int k = 0; k < 27; k++) mt[k] = 4'h0;
      end else if (!e) begin
         expv = model_out();
         for (int k = 26; k > 0; k--) mt[k] = mt[k-1];
         mt[0] = m;
      end else begin
         expv = last_exp;
      end
      exp_q.push_back(expv);
      last_exp = expv;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check_eq("sb_empty", 32'd1, 32'd0);
      end else begin
         check_eq("out", 32'(out), 32'(exp_q.pop_front()));
      end
      for (int k = 0; k < 27; k++) begin
         check_eq($sformatf("tap%0d", k), 32'(tap_o[k]), 32'(mt[k]));
      end
   endtask

   task automatic load_nominal();
      for (int k = 0; k < 27; k++) h[k] = NOM[k];
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] frozen;
      n_checks = 0;
      n_fail   = 0;
      last_exp = 16'h0;
      for (int k = 0; k < 27; k++) mt[k] = 4'h0;
      load_nominal();
      rst_n = 1'b0; clr = 1'b0; en_n = 1'b1; i_mag = 4'd9;

      // 1: reset held with a nonzero sample and enable off
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 4'd9);
      check_eq("reset_out", 32'(out), 32'd0);

      // 2: impulse response reproduces the coefficients in order
      step(1'b1, 1'b1, 1'b0, 4'd0);
      step(1'b1, 1'b0, 1'b0, 4'd1);
      for (int i = 0; i < 27; i++) begin
         step(1'b1, 1'b0, 1'b0, 4'd0);
         check_eq($sformatf("impulse%0d", i), 32'(out), 32'({7'd0, NOM[i]}));
      end
      step(1'b1, 1'b0, 1'b0, 4'd0);
      check_eq("impulse_tail", 32'(out), 32'd0);

      // 3: DC steps settle to sum(h) * sample
      for (int i = 0; i < 29; i++) step(1'b1, 1'b0, 1'b0, 4'd1);
      check_eq("dc_plus1", 32'(out), 32'd476);
      for (int i = 0; i < 29; i++) step(1'b1, 1'b0, 1'b0, 4'b1001);
      check_eq("dc_minus7", 32'(out), 32'(16'hF2FC));

      // 4: ramp through every sample code
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 4'(i));

      // 5: hold with coefficient churn, then clr, then reset over clr
      frozen = out;
      for (int i = 0; i < 5; i++) begin
         for (int k = 0; k < 27; k++) h[k] = 9'($urandom_range(0, 511));
         step(1'b1, 1'b0, 1'b1, 4'($urandom_range(0, 15)));
      end
      check_eq("hold_out", 32'(out), 32'(frozen));
      load_nominal();
      step(1'b1, 1'b0, 1'b0, 4'd5);
      step(1'b1, 1'b1, 1'b0, 4'd5);
      check_eq("clr_out", 32'(out), 32'd0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 4'd3);
      step(1'b0, 1'b1, 1'b0, 4'd3);
      check_eq("rst_clr_out", 32'(out), 32'd0);

      // 6: output range boundaries
      for (int k = 0; k < 27; k++) h[k] = 9'h0FF;
      for (int i = 0; i < 29; i++) step(1'b1, 1'b0, 1'b0, 4'd7);
`ifdef FIR_SAT_EN
      check_eq("pos_boundary", 32'(out), 32'(16'h7FFF));
`else
      check_eq("pos_boundary", 32'(out), 32'(16'hBC43));
`endif
      for (int i = 0; i < 29; i++) step(1'b1, 1'b0, 1'b0, 4'b1000);
`ifdef FIR_SAT_EN
      check_eq("neg_boundary", 32'(out), 32'(16'h8000));
`else
      check_eq("neg_boundary", 32'(out), 32'd10456);
`endif

      // random samples, enables, clears and coefficients
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            for (int k = 0; k < 27; k++) h[k] = 9'($urandom_range(0, 511));
         end
         step(1'b1, ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
              4'($urandom_range(0, 15)));
      end

      if (exp_q.size() != 0) check_eq("sb_leftover", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
